// File: rtl/shapool_job_ctrl.sv
// rtl/shapool_job_ctrl.sv - job sequencer and result capture for the shapool hashing pool
// Optional cycle counter output enabled by SHAPOOL_JOB_CTRL_CYCLE_COUNT_EN.
module shapool_job_ctrl #(
    parameter int POOL_SIZE      = 2,
    parameter int POOL_SIZE_LOG2 = 1,
    parameter int NONCE_LAG      = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        job_start,
    input  logic [7:0]  job_msb,
    input  logic        job_abort,
    output logic        busy,
    output logic        pool_reset_n,
    output logic [7:0]  pool_nonce_msb,
    input  logic        pool_success,
    input  logic [31:0] pool_nonce,
    input  logic [7:0]  pool_match_flags,
    output logic        result_valid,
    input  logic        result_ready,
    output logic [1:0]  result_status,
    output logic [31:0] result_nonce,
    output logic [7:0]  result_flags
`ifdef SHAPOOL_JOB_CTRL_CYCLE_COUNT_EN
    ,
    output logic [39:0] result_cycles
`endif
);

    localparam int LW = 32 - POOL_SIZE_LOG2;

    localparam logic [1:0] ST_NONE      = 2'b00;
    localparam logic [1:0] ST_FOUND     = 2'b01;
    localparam logic [1:0] ST_EXHAUSTED = 2'b10;
    localparam logic [1:0] ST_ABORTED   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_REPORT
    } state_t;

    state_t            state_q, state_d;
    logic              pool_reset_n_q;
    logic [7:0]        msb_q, msb_d;
    logic              wrap_seen_q, wrap_seen_d;
    logic [LW-1:0]     prev_lower_q, prev_lower_d;
    logic [1:0]        status_q, status_d;
    logic [31:0]       nonce_q, nonce_d;
    logic [7:0]        flags_q, flags_d;

    logic [LW-1:0]             lower;
    logic [LW-1:0]             tested;
    logic [POOL_SIZE_LOG2-1:0] idx;
    logic [31:0]               found_nonce;
    logic                      exhausted;
    logic                      unused_nonce_bits;

    assign lower             = pool_nonce[LW-1:0];
    assign unused_nonce_bits = ^pool_nonce[31:LW];
    // The pool reports its counter NONCE_LAG steps after the nonce that actually hit.
    assign tested            = lower - LW'(NONCE_LAG);
    assign found_nonce       = {idx, tested} ^ {msb_q, 24'h0};
    assign exhausted         = wrap_seen_q && (lower == LW'(NONCE_LAG)) && (prev_lower_q != lower);

    always_comb begin
        idx = '0;
        for (int i = POOL_SIZE - 1; i >= 0; i--) begin
            if (pool_match_flags[i]) begin
                idx = POOL_SIZE_LOG2'(i);
            end
        end
    end

`ifdef SHAPOOL_JOB_CTRL_CYCLE_COUNT_EN
    logic [39:0] cnt_q, cnt_d;
    logic [39:0] cycles_q, cycles_d;
`endif

    always_comb begin
        state_d      = state_q;
        msb_d        = msb_q;
        wrap_seen_d  = wrap_seen_q;
        prev_lower_d = prev_lower_q;
        status_d     = status_q;
        nonce_d      = nonce_q;
        flags_d      = flags_q;
`ifdef SHAPOOL_JOB_CTRL_CYCLE_COUNT_EN
        cnt_d        = cnt_q;
        cycles_d     = cycles_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (job_start) begin
                    msb_d   = job_msb;
                    state_d = S_START;
                end
            end
            S_START: begin
                wrap_seen_d  = 1'b0;
                prev_lower_d = '0;
`ifdef SHAPOOL_JOB_CTRL_CYCLE_COUNT_EN
                cnt_d        = '0;
`endif
                state_d      = S_RUN;
            end
            S_RUN: begin
                prev_lower_d = lower;
                if ((&prev_lower_q) && (lower == '0)) begin
                    wrap_seen_d = 1'b1;
                end
`ifdef SHAPOOL_JOB_CTRL_CYCLE_COUNT_EN
                cnt_d = (&cnt_q) ? cnt_q : cnt_q + 40'd1;
`endif
                // A success coinciding with exhaustion is the pool re-finding nonce 0.
                if (job_abort) begin
                    status_d = ST_ABORTED;
                    state_d  = S_REPORT;
                end else if (exhausted) begin
                    status_d = ST_EXHAUSTED;
                    state_d  = S_REPORT;
                end else if (pool_success) begin
                    status_d = ST_FOUND;
                    nonce_d  = found_nonce;
                    flags_d  = pool_match_flags;
                    state_d  = S_REPORT;
                end
`ifdef SHAPOOL_JOB_CTRL_CYCLE_COUNT_EN
                if (state_d == S_REPORT) begin
                    cycles_d = cnt_d;
                end
`endif
            end
            S_REPORT: begin
                if (result_ready) begin
                    status_d = ST_NONE;
                    nonce_d  = '0;
                    flags_d  = '0;
`ifdef SHAPOOL_JOB_CTRL_CYCLE_COUNT_EN
                    cycles_d = '0;
`endif
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            pool_reset_n_q <= 1'b0;
            msb_q          <= '0;
            wrap_seen_q    <= 1'b0;
            prev_lower_q   <= '0;
            status_q       <= ST_NONE;
            nonce_q        <= '0;
            flags_q        <= '0;
        end else begin
            state_q        <= state_d;
            pool_reset_n_q <= (state_d == S_RUN);
            msb_q          <= msb_d;
            wrap_seen_q    <= wrap_seen_d;
            prev_lower_q   <= prev_lower_d;
            status_q       <= status_d;
            nonce_q        <= nonce_d;
            flags_q        <= flags_d;
        end
    end

`ifdef SHAPOOL_JOB_CTRL_CYCLE_COUNT_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            cycles_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            cycles_q <= cycles_d;
        end
    end

    assign result_cycles = cycles_q;
`endif

    assign busy           = (state_q != S_IDLE);
    assign pool_reset_n   = pool_reset_n_q;
    assign pool_nonce_msb = msb_q;
    assign result_valid   = (state_q == S_REPORT);
    assign result_status  = status_q;
    assign result_nonce   = nonce_q;
    assign result_flags   = flags_q;

endmodule

// File: tb/tb_shapool_job_ctrl.sv
// tb/tb_shapool_job_ctrl.sv - self-checking bench for shapool_job_ctrl
module tb_shapool_job_ctrl;

    localparam int POOL_SIZE = 2;
    localparam int LOG2      = 1;
    localparam int LAG       = 2;
    localparam int LW        = 32 - LOG2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        job_start;
    logic [7:0]  job_msb;
    logic        job_abort;
    logic        busy;
    logic        pool_reset_n;
    logic [7:0]  pool_nonce_msb;
    logic        pool_success;
    logic [31:0] pool_nonce;
    logic [7:0]  pool_match_flags;
    logic        result_valid;
    logic        result_ready;
    logic [1:0]  result_status;
    logic [31:0] result_nonce;
    logic [7:0]  result_flags;
`ifdef SHAPOOL_JOB_CTRL_CYCLE_COUNT_EN
    logic [39:0] result_cycles;
`endif

    int n_total = 0;
    int n_pass  = 0;

    shapool_job_ctrl #(.POOL_SIZE(POOL_SIZE), .POOL_SIZE_LOG2(LOG2), .NONCE_LAG(LAG)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .job_start        (job_start),
        .job_msb          (job_msb),
        .job_abort        (job_abort),
        .busy             (busy),
        .pool_reset_n     (pool_reset_n),
        .pool_nonce_msb   (pool_nonce_msb),
        .pool_success     (pool_success),
        .pool_nonce       (pool_nonce),
        .pool_match_flags (pool_match_flags),
        .result_valid     (result_valid),
        .result_ready     (result_ready),
        .result_status    (result_status),
        .result_nonce     (result_nonce),
        .result_flags     (result_flags)
`ifdef SHAPOOL_JOB_CTRL_CYCLE_COUNT_EN
        ,
        .result_cycles    (result_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  msb;
        logic [31:0] pn;
        logic [7:0]  flags;
        logic [31:0] exp_nonce;
    } vec_t;

    vec_t vecs[5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Winning nonce straight from the arithmetic definition.
    function automatic logic [31:0] model_nonce(input logic [7:0] msb, input logic [31:0] pn,
                                                input logic [7:0] flags);
        longint unsigned lw_mod = 64'd1 << LW;
        longint unsigned lower  = pn % lw_mod;
        longint unsigned tested = (lower + lw_mod - LAG) % lw_mod;
        longint unsigned idx    = 0;
        longint unsigned full;
        for (int i = POOL_SIZE - 1; i >= 0; i--) if (flags[i]) idx = i;
        full = (idx * lw_mod + tested) ^ (longint'(msb) << 24);
        return full[31:0];
    endfunction

    task automatic start_job(input logic [7:0] msb);
        job_msb   = msb;
        job_start = 1'b1;
        tick();
        job_start = 1'b0;
        check("start_busy", busy, 1);
        check("start_pool_held", pool_reset_n, 0);
        check("start_msb", pool_nonce_msb, msb);
        tick();
        check("run_pool_released", pool_reset_n, 1);
    endtask

    task automatic handshake();
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        check("hs_valid", result_valid, 0);
        check("hs_busy", busy, 0);
        check("hs_status", result_status, 0);
        check("hs_nonce", result_nonce, 0);
        check("hs_flags", result_flags, 0);
    endtask

    task automatic run_found(input logic [7:0] msb, input logic [31:0] pn, input logic [7:0] flags,
                             input int idle, input int hold, input logic [31:0] exp_nonce);
        start_job(msb);
        for (int c = 0; c < idle; c++) begin
            pool_nonce = $urandom_range(32'h10, 32'h7FFF_0000);
            tick();
        end
        pool_nonce       = pn;
        pool_match_flags = flags;
        pool_success     = 1'b1;
        tick();
        pool_success     = 1'b0;
        pool_nonce       = pn + 32'd5;
        check("found_valid", result_valid, 1);
        check("found_status", result_status, 2'b01);
        check("found_nonce", result_nonce, exp_nonce);
        check("found_flags", result_flags, flags);
        check("found_pool_halted", pool_reset_n, 0);
        for (int c = 0; c < hold; c++) begin
            job_abort = c[0];
            tick();
            check("hold_nonce", result_nonce, exp_nonce);
            check("hold_status", result_status, 2'b01);
            check("hold_valid", result_valid, 1);
            check("hold_pool", pool_reset_n, 0);
        end
        job_abort = 1'b0;
        handshake();
    endtask

    initial begin
        reset_n = 0; job_start = 0; job_msb = 0; job_abort = 0;
        pool_success = 0; pool_nonce = 32'h100; pool_match_flags = 0; result_ready = 0;
        tick(); tick();
        reset_n = 1;
        check("rst_busy", busy, 0);
        check("rst_pool", pool_reset_n, 0);
        check("rst_valid", result_valid, 0);
        check("rst_status", result_status, 0);
        check("rst_msb", pool_nonce_msb, 0);

        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        check("idle_ready_no_effect", {busy, result_valid}, 0);

        vecs[0] = '{8'h00, 32'h0000_0007, 8'h02, 32'h8000_0005};
        vecs[1] = '{8'hA5, 32'h0000_0007, 8'h03, 32'hA500_0005};
        vecs[2] = '{8'h00, 32'h0000_0001, 8'h01, 32'h7FFF_FFFF};
        vecs[3] = '{8'hFF, 32'h1234_5678, 8'h02, 32'h6D34_5676};
        vecs[4] = '{8'h3C, 32'h0000_0010, 8'hFC, 32'h3C00_000E};
        for (int v = 0; v < 5; v++)
            run_found(vecs[v].msb, vecs[v].pn, vecs[v].flags, v, (v == 0) ? 10 : 1, vecs[v].exp_nonce);

        // Exhaustion: wrap through zero, then success at lower==LAG is ignored.
        start_job(8'h11);
        pool_nonce = 32'h7FFF_FFFF; tick();
        pool_nonce = 32'h0000_0000; tick();
        pool_nonce = 32'h0000_0001; tick();
        pool_nonce = 32'h0000_0002; pool_success = 1; pool_match_flags = 8'h01; tick();
        pool_success = 0;
        check("exh_valid", result_valid, 1);
        check("exh_status", result_status, 2'b10);
        check("exh_nonce", result_nonce, 0);
        check("exh_flags", result_flags, 0);
        handshake();

        // Abort with a simultaneous start and success.
        start_job(8'h22);
        pool_nonce = 32'h50; tick();
        job_abort = 1; job_start = 1; pool_success = 1; pool_nonce = 32'h51;
        tick();
        job_abort = 0; job_start = 0; pool_success = 0;
        check("abort_status", result_status, 2'b11);
        check("abort_nonce", result_nonce, 0);
        check("abort_busy", busy, 1);
        check("abort_msb_kept", pool_nonce_msb, 8'h22);
        job_start = 1; tick(); job_start = 0;
        check("abort_start_ignored", result_status, 2'b11);
        check("abort_busy_hold", busy, 1);
        handshake();

        // Reset in the middle of a run, then a clean job.
        start_job(8'h77);
        pool_nonce = 32'h60; tick();
        reset_n = 0; pool_success = 1; tick(); reset_n = 1; pool_success = 0;
        check("mrst_busy", busy, 0);
        check("mrst_pool", pool_reset_n, 0);
        check("mrst_valid", result_valid, 0);
        check("mrst_status", result_status, 0);
        check("mrst_nonce", result_nonce, 0);
        check("mrst_flags", result_flags, 0);
        check("mrst_msb", pool_nonce_msb, 0);
        run_found(8'h00, 32'h0000_0007, 8'h02, 0, 0, 32'h8000_0005);

        // Randomized jobs against the arithmetic model.
        for (int r = 0; r < 25; r++) begin
            logic [7:0]  m;
            logic [31:0] pn;
            logic [7:0]  f;
            m  = 8'($urandom_range(0, 255));
            pn = $urandom & 32'h7FFF_FFFF;
            f  = 8'($urandom_range(0, 255));
            run_found(m, pn, f, $urandom_range(0, 4), $urandom_range(0, 3), model_nonce(m, pn, f));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
